// File: rtl/can_pkg.sv
// Shared CAN bit-level constants and the output bit payload.
package can_pkg;

    localparam logic RECESSIVE = 1'b1;
    localparam logic DOMINANT  = 1'b0;

    localparam int unsigned MODE_STUFF   = 0;
    localparam int unsigned MODE_DESTUFF = 1;

    typedef struct packed {
        logic is_stuff;
        logic data;
    } can_bit_t;

endpackage

// File: rtl/can_run_tracker.sv
// Tracks the current run of equal bits and flags when a stuff bit is due.
module can_run_tracker
    import can_pkg::*;
#(
    parameter int unsigned RUN_LEN = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic upd,
    input  logic upd_bit,
    input  logic upd_en,
    input  logic resync,
    input  logic resync_bit,
    output logic last_bit,
    output logic pend
);

    localparam int unsigned RUN_W = $clog2(RUN_LEN + 1);

    logic [RUN_W-1:0] run_cnt;
    logic [RUN_W-1:0] run_inc;

    // Saturating increment keeps run_cnt from passing RUN_LEN.
    always_comb begin
        run_inc = run_cnt;
        if (run_cnt < RUN_W'(RUN_LEN)) begin
            run_inc = run_cnt + RUN_W'(1);
        end
    end

    // A resync (stuff bit seen or inserted) starts a new run of length one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt  <= '0;
            last_bit <= RECESSIVE;
            pend     <= 1'b0;
        end else if (clr) begin
            run_cnt  <= '0;
            last_bit <= RECESSIVE;
            pend     <= 1'b0;
        end else if (resync) begin
            run_cnt  <= RUN_W'(1);
            last_bit <= resync_bit;
            pend     <= 1'b0;
        end else if (upd) begin
            last_bit <= upd_bit;
            if (!upd_en) begin
                run_cnt <= '0;
                pend    <= 1'b0;
            end else if (upd_bit == last_bit) begin
                run_cnt <= run_inc;
                pend    <= (run_inc == RUN_W'(RUN_LEN));
            end else begin
                run_cnt <= RUN_W'(1);
                pend    <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/can_bit_stuffer.sv
// CAN bit stuffer (MODE 0) / destuffer with violation check (MODE 1) on a 1-bit valid/ready stream.
module can_bit_stuffer
    import can_pkg::*;
#(
    parameter int unsigned RUN_LEN = 5,
    parameter int unsigned MODE    = 0,
    parameter int unsigned CNT_W   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             stuff_en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_data,
    output logic             out_is_stuff,
    output logic             stuff_err,
    output logic [CNT_W-1:0] stuff_cnt
);

    localparam can_bit_t IDLE_BIT = '{is_stuff: 1'b0, data: RECESSIVE};

    logic     last_bit;
    logic     pend;
    logic     slot_free;
    logic     accept;
    logic     stuff_emit;
    logic     drop;
    logic     upd;
    logic     resync;
    logic     resync_bit;
    can_bit_t out_q;

    can_run_tracker #(
        .RUN_LEN (RUN_LEN)
    ) u_run_tracker (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .upd        (upd),
        .upd_bit    (in_data),
        .upd_en     (stuff_en),
        .resync     (resync),
        .resync_bit (resync_bit),
        .last_bit   (last_bit),
        .pend       (pend)
    );

    // In stuff mode a pending stuff bit owns the next output slot, so input is held off.
    always_comb begin
        slot_free  = !out_valid || out_ready;
        in_ready   = slot_free && !((MODE == MODE_STUFF) && pend);
        accept     = in_valid && in_ready && !clr;
        stuff_emit = (MODE == MODE_STUFF) && pend && slot_free && !clr;
        drop       = (MODE == MODE_DESTUFF) && accept && pend && stuff_en;
        upd        = accept && !drop;
        resync     = stuff_emit || drop;
        resync_bit = drop ? in_data : !last_bit;
    end

    assign out_data     = out_q.data;
    assign out_is_stuff = out_q.is_stuff;

    // Output register, stuff counter and violation pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_q     <= IDLE_BIT;
            stuff_err <= 1'b0;
            stuff_cnt <= '0;
        end else begin
            stuff_err <= 1'b0;
            if (clr) begin
                out_valid <= 1'b0;
                out_q     <= IDLE_BIT;
                stuff_cnt <= '0;
            end else begin
                if (resync) begin
                    stuff_cnt <= stuff_cnt + CNT_W'(1);
                end
                if (drop && (in_data == last_bit)) begin
                    stuff_err <= 1'b1;
                end
                if (stuff_emit) begin
                    out_valid <= 1'b1;
                    out_q     <= '{is_stuff: 1'b1, data: !last_bit};
                end else if (upd) begin
                    out_valid <= 1'b1;
                    out_q     <= '{is_stuff: 1'b0, data: in_data};
                end else if (out_ready) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_can_bit_stuffer.sv
// Directed bench for can_bit_stuffer: stuffer, destuffer and a short-run/narrow-counter stuffer.
module tb_can_bit_stuffer;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [1:0] sel;
    logic       clr, stuff_en, in_valid, in_data;
    logic       tx_out_ready, rx_out_ready, wr_out_ready;
    logic       tx_in_ready, rx_in_ready, wr_in_ready, cur_ready;
    logic       tx_out_valid, tx_out_data, tx_out_is_stuff, tx_stuff_err;
    logic       rx_out_valid, rx_out_data, rx_out_is_stuff, rx_stuff_err;
    logic       wr_out_valid, wr_out_data, wr_out_is_stuff, wr_stuff_err;
    logic [2:0] tx_stuff_cnt, rx_stuff_cnt;
    logic [1:0] wr_stuff_cnt;

    logic [1:0] tx_q[$];
    logic [1:0] rx_q[$];
    logic [1:0] wr_q[$];
    int rx_err_seen = 0;
    int checks = 0;
    int errors = 0;

    can_bit_stuffer #(.RUN_LEN(5), .MODE(0), .CNT_W(3)) u_tx (
        .clk(clk), .rst_n(rst_n), .clr(clr), .stuff_en(stuff_en),
        .in_valid(in_valid && (sel == 2'd0)), .in_ready(tx_in_ready), .in_data(in_data),
        .out_valid(tx_out_valid), .out_ready(tx_out_ready), .out_data(tx_out_data),
        .out_is_stuff(tx_out_is_stuff), .stuff_err(tx_stuff_err), .stuff_cnt(tx_stuff_cnt));

    can_bit_stuffer #(.RUN_LEN(5), .MODE(1), .CNT_W(3)) u_rx (
        .clk(clk), .rst_n(rst_n), .clr(clr), .stuff_en(stuff_en),
        .in_valid(in_valid && (sel == 2'd1)), .in_ready(rx_in_ready), .in_data(in_data),
        .out_valid(rx_out_valid), .out_ready(rx_out_ready), .out_data(rx_out_data),
        .out_is_stuff(rx_out_is_stuff), .stuff_err(rx_stuff_err), .stuff_cnt(rx_stuff_cnt));

    can_bit_stuffer #(.RUN_LEN(3), .MODE(0), .CNT_W(2)) u_wr (
        .clk(clk), .rst_n(rst_n), .clr(clr), .stuff_en(stuff_en),
        .in_valid(in_valid && (sel == 2'd2)), .in_ready(wr_in_ready), .in_data(in_data),
        .out_valid(wr_out_valid), .out_ready(wr_out_ready), .out_data(wr_out_data),
        .out_is_stuff(wr_out_is_stuff), .stuff_err(wr_stuff_err), .stuff_cnt(wr_stuff_cnt));

    always_comb begin
        case (sel)
            2'd0:    cur_ready = tx_in_ready;
            2'd1:    cur_ready = rx_in_ready;
            default: cur_ready = wr_in_ready;
        endcase
    end

    // Record every output transfer as {is_stuff, data}.
    always @(posedge clk) begin
        if (tx_out_valid && tx_out_ready) tx_q.push_back({tx_out_is_stuff, tx_out_data});
        if (rx_out_valid && rx_out_ready) rx_q.push_back({rx_out_is_stuff, rx_out_data});
        if (wr_out_valid && wr_out_ready) wr_q.push_back({wr_out_is_stuff, wr_out_data});
        if (rx_stuff_err) rx_err_seen++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic send(input logic b, input logic en, output int stalls);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = b;
        stuff_en = en;
        do begin
            @(posedge clk);
            n++;
        end while (!cur_ready && n < 20);
        if (!cur_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
        end
        stalls = n - 1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic test_reset();
        sel = 2'd0; clr = 1'b0; stuff_en = 1'b1; in_valid = 1'b0; in_data = 1'b1;
        tx_out_ready = 1'b1; rx_out_ready = 1'b1; wr_out_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        checks += 6;
        if (tx_out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b required 0", tx_out_valid); end
        if (tx_out_data !== 1'b1) begin errors++; $display("FAIL rst_out_data: got %b required 1", tx_out_data); end
        if (tx_out_is_stuff !== 1'b0) begin errors++; $display("FAIL rst_is_stuff: got %b required 0", tx_out_is_stuff); end
        if (tx_stuff_cnt !== 3'd0) begin errors++; $display("FAIL rst_stuff_cnt: got %0d required 0", tx_stuff_cnt); end
        if ({tx_in_ready, rx_in_ready, wr_in_ready} !== 3'b111) begin
            errors++; $display("FAIL rst_in_ready: got %b required 111", {tx_in_ready, rx_in_ready, wr_in_ready});
        end
        if ({tx_stuff_err, rx_stuff_err} !== 2'b00) begin
            errors++; $display("FAIL rst_stuff_err: got %b required 00", {tx_stuff_err, rx_stuff_err});
        end
    endtask

    task automatic test_stuff();
        logic [1:0] exp [7] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00};
        int base, st, stall6;
        sel = 2'd0;
        do_clr();
        base = tx_q.size();
        stall6 = 0;
        for (int i = 0; i < 6; i++) begin
            send(1'b0, 1'b1, st);
            if (i == 5) stall6 = st;
        end
        repeat (3) @(negedge clk);
        checks += 3;
        if (stall6 !== 1) begin errors++; $display("FAIL stuff_stall: got %0d cycles required 1", stall6); end
        if (tx_q.size() - base !== 7) begin errors++; $display("FAIL stuff_len: got %0d required 7", tx_q.size() - base); end
        if (tx_stuff_cnt !== 3'd1) begin errors++; $display("FAIL stuff_cnt: got %0d required 1", tx_stuff_cnt); end
        for (int i = 0; i < 7 && base + i < tx_q.size(); i++) begin
            checks++;
            if (tx_q[base + i] !== exp[i]) begin
                errors++; $display("FAIL stuff_seq[%0d]: got %b required %b", i, tx_q[base + i], exp[i]);
            end
        end
    endtask

    task automatic test_two_runs();
        int base, st, nstuff;
        sel = 2'd0;
        do_clr();
        base = tx_q.size();
        for (int i = 0; i < 10; i++) send(1'b0, 1'b1, st);
        repeat (3) @(negedge clk);
        nstuff = 0;
        for (int i = base; i < tx_q.size(); i++) if (tx_q[i][1]) nstuff++;
        checks += 3;
        if (tx_q.size() - base !== 12) begin errors++; $display("FAIL ten_len: got %0d required 12", tx_q.size() - base); end
        if (nstuff !== 2) begin errors++; $display("FAIL ten_stuffs: got %0d required 2", nstuff); end
        if (tx_stuff_cnt !== 3'd2) begin errors++; $display("FAIL ten_cnt: got %0d required 2", tx_stuff_cnt); end
    endtask

    task automatic test_destuff_ok();
        logic b [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        int base, ebase, st;
        sel = 2'd1;
        do_clr();
        base = rx_q.size();
        ebase = rx_err_seen;
        for (int i = 0; i < 7; i++) send(b[i], 1'b1, st);
        repeat (3) @(negedge clk);
        checks += 3;
        if (rx_q.size() - base !== 6) begin errors++; $display("FAIL dok_len: got %0d required 6", rx_q.size() - base); end
        if (rx_stuff_cnt !== 3'd1) begin errors++; $display("FAIL dok_cnt: got %0d required 1", rx_stuff_cnt); end
        if (rx_err_seen - ebase !== 0) begin errors++; $display("FAIL dok_err: got %0d pulses required 0", rx_err_seen - ebase); end
        for (int i = base; i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== 2'b01) begin errors++; $display("FAIL dok_seq[%0d]: got %b required 01", i - base, rx_q[i]); end
        end
    endtask

    task automatic test_destuff_err();
        int base, ebase, st;
        sel = 2'd1;
        do_clr();
        base = rx_q.size();
        ebase = rx_err_seen;
        for (int i = 0; i < 6; i++) send(1'b0, 1'b1, st);
        repeat (3) @(negedge clk);
        checks += 3;
        if (rx_q.size() - base !== 5) begin errors++; $display("FAIL derr_len: got %0d required 5", rx_q.size() - base); end
        if (rx_err_seen - ebase !== 1) begin errors++; $display("FAIL derr_err: got %0d pulses required 1", rx_err_seen - ebase); end
        if (rx_stuff_cnt !== 3'd1) begin errors++; $display("FAIL derr_cnt: got %0d required 1", rx_stuff_cnt); end
        for (int i = base; i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== 2'b00) begin errors++; $display("FAIL derr_seq[%0d]: got %b required 00", i - base, rx_q[i]); end
        end
    endtask

    task automatic test_backpressure();
        logic [1:0] exp [7] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00};
        int base, st;
        logic hold;
        sel = 2'd0;
        do_clr();
        base = tx_q.size();
        fork
            begin
                for (int i = 0; i < 6; i++) send(1'b0, 1'b1, st);
            end
            begin
                repeat (2) @(negedge clk);
                tx_out_ready = 1'b0;
                hold = tx_out_data;
                checks++;
                if (tx_out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b required 1", tx_out_valid); end
                repeat (3) begin
                    @(negedge clk);
                    checks++;
                    if (tx_out_valid !== 1'b1 || tx_out_data !== hold) begin
                        errors++; $display("FAIL bp_hold: got v=%b d=%b required v=1 d=%b", tx_out_valid, tx_out_data, hold);
                    end
                end
                tx_out_ready = 1'b1;
            end
        join
        repeat (3) @(negedge clk);
        checks += 2;
        if (tx_q.size() - base !== 7) begin errors++; $display("FAIL bp_len: got %0d required 7", tx_q.size() - base); end
        if (tx_stuff_cnt !== 3'd1) begin errors++; $display("FAIL bp_cnt: got %0d required 1", tx_stuff_cnt); end
        for (int i = 0; i < 7 && base + i < tx_q.size(); i++) begin
            checks++;
            if (tx_q[base + i] !== exp[i]) begin
                errors++; $display("FAIL bp_seq[%0d]: got %b required %b", i, tx_q[base + i], exp[i]);
            end
        end
    endtask

    task automatic test_no_stuff_en();
        int base, st;
        sel = 2'd0;
        do_clr();
        base = tx_q.size();
        for (int i = 0; i < 8; i++) send(1'b0, 1'b0, st);
        repeat (3) @(negedge clk);
        checks += 2;
        if (tx_q.size() - base !== 8) begin errors++; $display("FAIL noen_len: got %0d required 8", tx_q.size() - base); end
        if (tx_stuff_cnt !== 3'd0) begin errors++; $display("FAIL noen_cnt: got %0d required 0", tx_stuff_cnt); end
        for (int i = base; i < tx_q.size(); i++) begin
            checks++;
            if (tx_q[i] !== 2'b00) begin errors++; $display("FAIL noen_seq[%0d]: got %b required 00", i - base, tx_q[i]); end
        end
        for (int i = 0; i < 5; i++) send(1'b0, 1'b1, st);
        repeat (3) @(negedge clk);
        checks++;
        if (tx_stuff_cnt !== 3'd1) begin errors++; $display("FAIL pre_clr_cnt: got %0d required 1", tx_stuff_cnt); end
        do_clr();
        checks++;
        if (tx_stuff_cnt !== 3'd0) begin errors++; $display("FAIL clr_cnt: got %0d required 0", tx_stuff_cnt); end
        base = tx_q.size();
        for (int i = 0; i < 5; i++) send(1'b1, 1'b1, st);
        repeat (3) @(negedge clk);
        checks += 2;
        if (tx_q.size() - base !== 6) begin errors++; $display("FAIL clr_len: got %0d required 6", tx_q.size() - base); end
        else if (tx_q[base + 5] !== 2'b10) begin errors++; $display("FAIL clr_stuff: got %b required 10", tx_q[base + 5]); end
        if (tx_stuff_cnt !== 3'd1) begin errors++; $display("FAIL clr_cnt2: got %0d required 1", tx_stuff_cnt); end
    endtask

    task automatic test_wrap();
        int base, st;
        sel = 2'd2;
        do_clr();
        base = wr_q.size();
        for (int i = 1; i <= 16; i++) begin
            send(1'b0, 1'b1, st);
            if (i == 10) begin
                checks++;
                if (wr_stuff_cnt !== 2'd3) begin errors++; $display("FAIL wrap_cnt10: got %0d required 3", wr_stuff_cnt); end
            end
            if (i == 13) begin
                checks++;
                if (wr_stuff_cnt !== 2'd0) begin errors++; $display("FAIL wrap_cnt13: got %0d required 0", wr_stuff_cnt); end
            end
        end
        repeat (3) @(negedge clk);
        checks += 2;
        if (wr_stuff_cnt !== 2'd1) begin errors++; $display("FAIL wrap_cnt16: got %0d required 1", wr_stuff_cnt); end
        if (wr_q.size() - base !== 21) begin errors++; $display("FAIL wrap_len: got %0d required 21", wr_q.size() - base); end
    endtask

    task automatic test_reset_pend();
        int base, st;
        sel = 2'd2;
        do_clr();
        for (int i = 0; i < 3; i++) send(1'b1, 1'b1, st);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (wr_out_valid !== 1'b0) begin errors++; $display("FAIL rp_valid: got %b required 0", wr_out_valid); end
        rst_n = 1'b1;
        base = wr_q.size();
        checks += 2;
        if (wr_in_ready !== 1'b1) begin errors++; $display("FAIL rp_in_ready: got %b required 1", wr_in_ready); end
        if (wr_stuff_cnt !== 2'd0) begin errors++; $display("FAIL rp_cnt: got %0d required 0", wr_stuff_cnt); end
        repeat (5) @(negedge clk);
        checks += 2;
        if (wr_q.size() !== base) begin errors++; $display("FAIL rp_no_stuff: got %0d bits required 0", wr_q.size() - base); end
        if (wr_stuff_cnt !== 2'd0) begin errors++; $display("FAIL rp_cnt_after: got %0d required 0", wr_stuff_cnt); end
    endtask

    initial begin
        test_reset();
        test_stuff();
        test_two_runs();
        test_destuff_ok();
        test_destuff_err();
        test_backpressure();
        test_no_stuff_en();
        test_wrap();
        test_reset_pend();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
        $finish;
    end

endmodule

// File: doc/can_bit_stuffer.md
CAN_BIT_STUFFER -- requirements
Module: can_bit_stuffer

Interface
REQ-001 SHALL have parameter RUN_LEN, default 5: length of an equal-bit run that triggers a stuff bit; legal range 2..15.
REQ-002 SHALL have parameter MODE, default 0: 0 = stuff (TX, insert), 1 = destuff (RX, remove and check).
REQ-003 SHALL have parameter CNT_W, default 3: width of stuff_cnt.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port clr, input, 1: synchronous frame restart (start of frame).
REQ-007 SHALL have port stuff_en, input, 1: stuffing/destuffing active for the bit being accepted.
REQ-008 SHALL have ports in_valid (input, 1), in_ready (output, 1) and in_data (input, 1): upstream bit handshake.
REQ-009 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_data (output, 1) and out_is_stuff (output, 1): downstream bit handshake; out_is_stuff flags an inserted stuff bit.
REQ-010 SHALL have port stuff_err, input-side result, output, 1: one-cycle pulse on a stuff violation (MODE 1 only; tied 0 in MODE 0).
REQ-011 SHALL have port stuff_cnt, output, CNT_W: count of stuff bits inserted or removed since clr, modulo 2^CNT_W.

Function
REQ-012 Transfers SHALL occur only on valid&&ready; the output register SHALL hold out_data/out_is_stuff stable while out_valid&&!out_ready.
REQ-013 Latency from accepted input bit to out_valid SHALL be exactly 1 cycle when the output register is free.
REQ-014 in_ready SHALL be (!out_valid || out_ready) && !(MODE==0 && pend).
REQ-015 Run tracking on every accepted bit b with stuff_en=1: if b==last_bit then run_cnt+1, else run_cnt=1; last_bit=b.
REQ-016 When run_cnt reaches RUN_LEN, pend SHALL be set and run_cnt SHALL NOT exceed RUN_LEN.
REQ-017 MODE 0: while pend, the next free output slot SHALL carry ~last_bit with out_is_stuff=1; then pend=0, last_bit=~last_bit, run_cnt=1, stuff_cnt+1.
REQ-018 MODE 1: while pend, the next accepted bit SHALL be dropped (not forwarded) and SHALL set pend=0, last_bit=b, run_cnt=1 and stuff_cnt+1; if b==last_bit, stuff_err SHALL pulse for 1 cycle.
REQ-019 Accepted bits with stuff_en=0 SHALL pass unchanged, set run_cnt=0 and pend=0, and update last_bit.
REQ-020 clr SHALL set run_cnt=0, last_bit=1 (recessive), pend=0 and stuff_cnt=0, and SHALL empty the output register; any in_valid in the same cycle SHALL be ignored.
REQ-021 stuff_cnt SHALL wrap from 2^CNT_W-1 to 0 without a flag.
REQ-022 A stuff bit counts as the first bit of the next run; 10 identical input bits with RUN_LEN=5 SHALL yield two stuff bits.

Reset
REQ-023 On rst_n=0, asynchronously: out_valid=0, out_data=1, out_is_stuff=0, stuff_err=0, stuff_cnt=0, run_cnt=0, last_bit=1, pend=0.
REQ-024 in_ready SHALL be 1 in the first cycle after reset release; a reset mid-frame SHALL discard any pending stuff bit.

Structure
REQ-025 Shared package can_pkg SHALL hold RECESSIVE=1'b1, DOMINANT=1'b0 and MODE_STUFF/MODE_DESTUFF constants.
REQ-026 Run tracking (run_cnt, last_bit, pend) SHALL be one sub-module, can_run_tracker, parametrised by RUN_LEN; stuff/destuff selection and handshake live in the top level.

Verification
REQ-027 MODE 0, RUN_LEN 5, out_ready=1, input 0,0,0,0,0,0 -> output 0,0,0,0,0,1(stuff),0; in_ready low for 1 cycle; stuff_cnt=1.
REQ-028 MODE 1, input 1,1,1,1,1,0,1 -> forwards 1,1,1,1,1,1; stuff_cnt=1; no stuff_err.
REQ-029 MODE 1, input 0 x6 -> sixth bit dropped; stuff_err pulses once.
REQ-030 MODE 0, out_ready held 0 for 3 cycles mid-run -> out_data stable, no bit lost or duplicated; sequence matches REQ-027.
REQ-031 stuff_en=0 during 8 zeros -> 8 bits out, no stuff; clr mid-frame -> stuff_cnt=0, next 5 ones trigger a stuff 0.
REQ-032 RUN_LEN=3, CNT_W=2, 16 identical bits -> stuff_cnt wraps 3->0; rst_n asserted with pend set -> no stuff bit emitted after release.
